// File: rtl/bias_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Package  : bias_pkg                                                     |
// | Purpose  : Shared bias type and geometry helpers for bias storage/adds  |
// | Revision : 1.0  initial release                                         |
// +-------------------------------------------------------------------------+
package bias_pkg;

    localparam int BIAS_W_DEFAULT = 32;

    typedef logic signed [BIAS_W_DEFAULT-1:0] bias_t;

    // Write beats needed to carry one full output group
    function automatic int calc_wpg(input int lanes, input int bias_w, input int wr_w);
        return (lanes * bias_w) / wr_w;
    endfunction

    function automatic int calc_grp_w(input int max_groups);
        return $clog2(max_groups);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bias_buffer_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Interface: bias_buffer_if                                               |
// | Purpose  : Write-stream, bank-control and group-read signals            |
// | Revision : 1.0  initial release                                         |
// +-------------------------------------------------------------------------+
interface bias_buffer_if
    import bias_pkg::*;
#(
    parameter int LANES      = 8,
    parameter int BIAS_W     = BIAS_W_DEFAULT,
    parameter int WR_W       = 128,
    parameter int MAX_GROUPS = 128
);
    localparam int GRP_W = calc_grp_w(MAX_GROUPS);

    logic                     wr_en;
    logic [WR_W-1:0]          wr_data;
    logic                     wr_addr_rst;
    logic                     bank_swap;
    logic                     rd_en;
    logic [GRP_W-1:0]         rd_group;
    logic signed [BIAS_W-1:0] bias_out [LANES];
    logic                     rd_valid;
    logic                     rd_err;
    logic                     wr_overflow;
    logic [GRP_W:0]           active_groups;

    modport slave (
        input  wr_en, wr_data, wr_addr_rst, bank_swap, rd_en, rd_group,
        output bias_out, rd_valid, rd_err, wr_overflow, active_groups
    );

    modport master (
        output wr_en, wr_data, wr_addr_rst, bank_swap, rd_en, rd_group,
        input  bias_out, rd_valid, rd_err, wr_overflow, active_groups
    );

endinterface
`default_nettype wire

// File: rtl/bias_bank_ram.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module   : bias_bank_ram                                                |
// | Purpose  : Simple dual-port RAM, registered read, contents not reset    |
// | Revision : 1.0  initial release                                         |
// +-------------------------------------------------------------------------+
module bias_bank_ram #(
    parameter int DEPTH = 128,
    parameter int WIDTH = 128
) (
    input  wire logic                     clk,
    input  wire logic                     i_we,
    input  wire logic [$clog2(DEPTH)-1:0] i_waddr,
    input  wire logic [WIDTH-1:0]         i_wdata,
    input  wire logic                     i_re,
    input  wire logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic      [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Read data holds while i_re is low
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/bias_buffer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module   : bias_buffer                                                  |
// | Purpose  : Ping-pong bias store; beat-packed writes, full-group reads   |
// | Revision : 1.0  initial release                                         |
// +-------------------------------------------------------------------------+
module bias_buffer
    import bias_pkg::*;
#(
    parameter int LANES      = 8,
    parameter int BIAS_W     = BIAS_W_DEFAULT,
    parameter int WR_W       = 128,
    parameter int MAX_GROUPS = 128,
    parameter int WPG        = calc_wpg(LANES, BIAS_W, WR_W),
    parameter int GRP_W      = calc_grp_w(MAX_GROUPS)
) (
    input wire logic     clk,
    input wire logic     rst,
    bias_buffer_if.slave bus
);

    localparam int             c_lanes_per_beat = WR_W / BIAS_W;
    localparam int             c_slc_w          = (WPG > 1) ? $clog2(WPG) : 1;
    localparam logic [GRP_W:0] c_full_row       = (GRP_W+1)'(MAX_GROUPS);

    // Write pointer kept as (row, slice) so wp/WPG and wp%WPG cost nothing
    logic [GRP_W:0]     r_row;
    logic [c_slc_w-1:0] r_slice;
    logic               r_overflow;
    logic               r_active;
    logic [GRP_W:0]     r_active_groups;
    logic               r_rd_valid;
    logic               r_rd_err;
    logic               r_rd_seen;
    logic               r_rd_bank;

    logic               w_full;
    logic               w_wr_accept;
    logic               w_wr_drop;
    logic               w_slice_last;
    logic [GRP_W:0]     w_row_nxt;
    logic [c_slc_w-1:0] w_slice_nxt;
    logic [WR_W-1:0]    w_rd_slice [2][WPG];

    assign w_full       = (r_row == c_full_row);
    assign w_wr_accept  = bus.wr_en && !bus.wr_addr_rst && !w_full;
    assign w_wr_drop    = bus.wr_en && !bus.wr_addr_rst && w_full;
    assign w_slice_last = (r_slice == c_slc_w'(WPG-1));

    always_comb begin
        w_row_nxt   = r_row;
        w_slice_nxt = r_slice;
        if (w_wr_accept) begin
            if (w_slice_last) begin
                w_slice_nxt = '0;
                w_row_nxt   = r_row + (GRP_W+1)'(1);
            end else begin
                w_slice_nxt = r_slice + c_slc_w'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_row           <= '0;
            r_slice         <= '0;
            r_overflow      <= 1'b0;
            r_active        <= 1'b0;
            r_active_groups <= '0;
        end else begin
            // A beat written alongside the swap still counts toward the new active fill
            if (bus.bank_swap) begin
                r_active        <= ~r_active;
                r_active_groups <= w_row_nxt;
            end
            if (bus.bank_swap || bus.wr_addr_rst) begin
                r_row   <= '0;
                r_slice <= '0;
            end else begin
                r_row   <= w_row_nxt;
                r_slice <= w_slice_nxt;
            end
            if (bus.wr_addr_rst) begin
                r_overflow <= 1'b0;
            end else if (w_wr_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_err   <= 1'b0;
            r_rd_seen  <= 1'b0;
            r_rd_bank  <= 1'b0;
        end else begin
            r_rd_valid <= bus.rd_en;
            r_rd_err   <= bus.rd_en && ({1'b0, bus.rd_group} >= r_active_groups);
            if (bus.rd_en) begin
                r_rd_seen <= 1'b1;
                r_rd_bank <= r_active;
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        for (genvar s = 0; s < WPG; s++) begin : g_slice
            logic w_we;
            logic w_re;
            assign w_we = w_wr_accept && (r_active != 1'(b)) && (r_slice == c_slc_w'(s));
            assign w_re = bus.rd_en && (r_active == 1'(b));

            bias_bank_ram #(
                .DEPTH (MAX_GROUPS),
                .WIDTH (WR_W)
            ) u_ram (
                .clk     (clk),
                .i_we    (w_we),
                .i_waddr (r_row[GRP_W-1:0]),
                .i_wdata (bus.wr_data),
                .i_re    (w_re),
                .i_raddr (bus.rd_group),
                .o_rdata (w_rd_slice[b][s])
            );
        end
    end

    // RAM output is unreset, so mask it until the first read after reset
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign bus.bias_out[i] = r_rd_seen
            ? w_rd_slice[r_rd_bank][i / c_lanes_per_beat][(i % c_lanes_per_beat)*BIAS_W +: BIAS_W]
            : '0;
    end

    assign bus.rd_valid      = r_rd_valid;
    assign bus.rd_err        = r_rd_err;
    assign bus.wr_overflow   = r_overflow;
    assign bus.active_groups = r_active_groups;

endmodule
`default_nettype wire

// File: tb/tb_bias_buffer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module   : tb_bias_buffer                                               |
// | Purpose  : Randomised self-checking bench against a bank/beat model     |
// | Revision : 1.0  initial release                                         |
// +-------------------------------------------------------------------------+
module tb_bias_buffer;
    import bias_pkg::*;

    localparam int LANES  = 8;
    localparam int BIAS_W = 32;
    localparam int WR_W   = 128;
    localparam int MAXG   = 128;
    localparam int WPG    = 2;
    localparam int GW     = 7;
    localparam int GV_W   = LANES*BIAS_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bias_buffer_if #(.LANES(LANES), .BIAS_W(BIAS_W), .WR_W(WR_W), .MAX_GROUPS(MAXG)) bus ();

    bias_buffer #(.LANES(LANES), .BIAS_W(BIAS_W), .WR_W(WR_W), .MAX_GROUPS(MAXG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: each bank row is one whole group, lane i at bits i*BIAS_W
    logic [GV_W-1:0] m_mem [2][MAXG];
    int              m_active;
    int              m_groups;
    int              m_wp;
    bit              m_ovf;
    logic [GV_W-1:0] exp_bias;
    bit              exp_valid;
    bit              exp_err;

    function automatic logic [GV_W-1:0] got_flat();
        logic [GV_W-1:0] f;
        for (int i = 0; i < LANES; i++) f[i*BIAS_W +: BIAS_W] = bus.bias_out[i];
        return f;
    endfunction

    function automatic logic [WR_W-1:0] rnd_beat();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        m_active = 0; m_groups = 0; m_wp = 0; m_ovf = 0;
        exp_bias = '0; exp_valid = 0; exp_err = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.wr_en = 0; bus.wr_addr_rst = 0; bus.bank_swap = 0; bus.rd_en = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Drive one cycle and advance the model; outputs sampled 1 time unit after the edge
    task automatic do_cycle(input bit we, input logic [WR_W-1:0] wd, input bit war,
                            input bit sw, input bit re, input int grp);
        bus.wr_en = we; bus.wr_data = wd; bus.wr_addr_rst = war;
        bus.bank_swap = sw; bus.rd_en = re; bus.rd_group = GW'(grp);
        exp_valid = re;
        exp_err   = re && (grp >= m_groups);
        if (re) exp_bias = m_mem[m_active][grp];
        if (we && !war) begin
            if (m_wp < MAXG*WPG) begin
                m_mem[1-m_active][m_wp/WPG][(m_wp%WPG)*WR_W +: WR_W] = wd;
                m_wp++;
            end else begin
                m_ovf = 1;
            end
        end
        if (war) begin m_wp = 0; m_ovf = 0; end
        if (sw) begin m_groups = m_wp / WPG; m_active = 1 - m_active; m_wp = 0; end
        @(posedge clk); #1;
        bus.wr_en = 0; bus.wr_addr_rst = 0; bus.bank_swap = 0; bus.rd_en = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({bus.rd_valid, bus.rd_err, bus.wr_overflow} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags got=%b exp=000", {bus.rd_valid, bus.rd_err, bus.wr_overflow});
        end
        n_checks++;
        if (bus.active_groups !== 8'd0) begin
            n_fail++; $display("FAIL reset_active_groups got=%0d exp=0", bus.active_groups);
        end
        n_checks++;
        if (got_flat() !== '0) begin
            n_fail++; $display("FAIL reset_bias got=%h exp=0", got_flat());
        end
    endtask

    task automatic test_basic();
        logic [WR_W-1:0] beats [4];
        for (int k = 0; k < 4; k++) begin
            beats[k] = rnd_beat();
            do_cycle(1, beats[k], 0, 0, 0, 0);
        end
        do_cycle(0, '0, 0, 1, 0, 0);
        n_checks++;
        if (bus.active_groups !== 8'(m_groups) || m_groups != 2) begin
            n_fail++; $display("FAIL basic_active_groups got=%0d exp=2", bus.active_groups);
        end
        for (int g = 0; g < 2; g++) begin
            do_cycle(0, '0, 0, 0, 1, g);
            n_checks++;
            if ({bus.rd_valid, bus.rd_err, got_flat()} !== {1'b1, 1'b0, exp_bias}) begin
                n_fail++;
                $display("FAIL basic_read g=%0d got=%b%b_%h exp=10_%h", g, bus.rd_valid, bus.rd_err, got_flat(), exp_bias);
            end
            n_checks++;
            if (bus.bias_out[0] !== beats[2*g][31:0] || bus.bias_out[7] !== beats[2*g+1][127:96]) begin
                n_fail++;
                $display("FAIL basic_lane_map g=%0d got=%h/%h exp=%h/%h", g, bus.bias_out[0], bus.bias_out[7],
                         beats[2*g][31:0], beats[2*g+1][127:96]);
            end
        end
        // Bias holds and valid drops on an idle cycle
        do_cycle(0, '0, 0, 0, 0, 0);
        n_checks++;
        if ({bus.rd_valid, got_flat()} !== {1'b0, exp_bias}) begin
            n_fail++; $display("FAIL basic_hold got=%b_%h exp=0_%h", bus.rd_valid, got_flat(), exp_bias);
        end
    endtask

    task automatic test_rd_err();
        do_cycle(0, '0, 0, 0, 1, 2);
        n_checks++;
        if ({bus.rd_valid, bus.rd_err} !== 2'b11) begin
            n_fail++; $display("FAIL rd_err_range got=%b%b exp=11", bus.rd_valid, bus.rd_err);
        end
    endtask

    task automatic test_overflow();
        do_cycle(0, '0, 1, 0, 0, 0);
        for (int k = 0; k < MAXG*WPG; k++) do_cycle(1, rnd_beat(), 0, 0, 0, 0);
        n_checks++;
        if (bus.wr_overflow !== 1'b0) begin
            n_fail++; $display("FAIL ovf_early got=%b exp=0", bus.wr_overflow);
        end
        do_cycle(1, rnd_beat(), 0, 0, 0, 0);
        n_checks++;
        if (bus.wr_overflow !== m_ovf || !m_ovf) begin
            n_fail++; $display("FAIL ovf_set got=%b exp=1", bus.wr_overflow);
        end
        do_cycle(0, '0, 0, 1, 0, 0);
        n_checks++;
        if (bus.active_groups !== 8'd128) begin
            n_fail++; $display("FAIL ovf_active_groups got=%0d exp=128", bus.active_groups);
        end
        for (int r = 0; r < 6; r++) begin
            int g;
            g = (r == 0) ? MAXG-1 : int'($urandom_range(0, MAXG-1));
            do_cycle(0, '0, 0, 0, 1, g);
            n_checks++;
            if ({bus.rd_err, got_flat()} !== {exp_err, exp_bias}) begin
                n_fail++; $display("FAIL full_read g=%0d got=%b_%h exp=%b_%h", g, bus.rd_err, got_flat(), exp_err, exp_bias);
            end
        end
        do_cycle(0, '0, 1, 0, 0, 0);
        n_checks++;
        if (bus.wr_overflow !== 1'b0) begin
            n_fail++; $display("FAIL ovf_clear got=%b exp=0", bus.wr_overflow);
        end
    endtask

    task automatic test_ping_pong();
        int na, nb;
        na = int'($urandom_range(3, 6));
        nb = int'($urandom_range(3, 6));
        do_cycle(0, '0, 1, 0, 0, 0);
        for (int k = 0; k < na*WPG; k++) do_cycle(1, rnd_beat(), 0, 0, 0, 0);
        do_cycle(0, '0, 0, 1, 0, 0);
        // Stream reads of layer A while layer B loads into the shadow
        for (int k = 0; k < nb*WPG; k++) begin
            int g;
            g = int'($urandom_range(0, na-1));
            do_cycle(1, rnd_beat(), k == 0, 0, 1, g);
            n_checks++;
            if ({bus.rd_valid, bus.rd_err, got_flat()} !== {exp_valid, exp_err, exp_bias}) begin
                n_fail++; $display("FAIL pp_read_a g=%0d got=%b%b_%h exp=%b%b_%h", g, bus.rd_valid, bus.rd_err,
                                   got_flat(), exp_valid, exp_err, exp_bias);
            end
        end
        // The first beat above was dropped by the pointer reset, so one more completes B
        do_cycle(1, rnd_beat(), 0, 0, 0, 0);
        do_cycle(0, '0, 0, 1, 0, 0);
        n_checks++;
        if (bus.active_groups !== 8'(nb)) begin
            n_fail++; $display("FAIL pp_active_groups got=%0d exp=%0d", bus.active_groups, nb);
        end
        for (int g = 0; g < nb + 1; g++) begin
            do_cycle(0, '0, 0, 0, 1, g);
            n_checks++;
            if ({bus.rd_err, (exp_err ? '0 : got_flat())} !== {exp_err, (exp_err ? '0 : exp_bias)}) begin
                n_fail++; $display("FAIL pp_read_b g=%0d got=%b_%h exp=%b_%h", g, bus.rd_err, got_flat(), exp_err, exp_bias);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [WR_W-1:0] beat;
        do_cycle(0, '0, 1, 0, 0, 0);
        for (int k = 0; k < 2*WPG; k++) do_cycle(1, rnd_beat(), 0, 0, 0, 0);
        do_cycle(0, '0, 0, 1, 0, 0);
        do_cycle(1, rnd_beat(), 0, 0, 0, 0);
        do_cycle(1, rnd_beat(), 0, 0, 0, 0);
        beat = rnd_beat();
        do_cycle(1, beat, 0, 1, 1, 1);
        n_checks++;
        if ({bus.rd_valid, bus.rd_err, got_flat()} !== {1'b1, 1'b0, exp_bias}) begin
            n_fail++; $display("FAIL simul_old_bank got=%b%b_%h exp=10_%h", bus.rd_valid, bus.rd_err, got_flat(), exp_bias);
        end
        n_checks++;
        if (bus.active_groups !== 8'd1) begin
            n_fail++; $display("FAIL simul_active_groups got=%0d exp=1", bus.active_groups);
        end
        // The beat sits in slice 0 of the partial group 1 of the bank that just went active
        do_cycle(0, '0, 0, 0, 1, 1);
        n_checks++;
        if ({bus.rd_err, got_flat() & {{(GV_W-WR_W){1'b0}}, {WR_W{1'b1}}}} !== {1'b1, {(GV_W-WR_W){1'b0}}, beat}) begin
            n_fail++; $display("FAIL simul_beat_landed got=%b_%h exp=1_%h", bus.rd_err, got_flat(), beat);
        end
    endtask

    task automatic test_partial_reset();
        do_cycle(0, '0, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) do_cycle(1, rnd_beat(), 0, 0, 0, 0);
        do_cycle(0, '0, 0, 1, 0, 0);
        n_checks++;
        if (bus.active_groups !== 8'd1) begin
            n_fail++; $display("FAIL partial_group got=%0d exp=1", bus.active_groups);
        end
        do_cycle(1, rnd_beat(), 0, 0, 0, 0);
        do_reset();
        n_checks++;
        if (bus.active_groups !== 8'd0) begin
            n_fail++; $display("FAIL midload_rst_groups got=%0d exp=0", bus.active_groups);
        end
        for (int k = 0; k < 3; k++) begin
            int g;
            g = int'($urandom_range(0, MAXG-1));
            do_cycle(0, '0, 0, 0, 1, g);
            n_checks++;
            if ({bus.rd_valid, bus.rd_err} !== 2'b11) begin
                n_fail++; $display("FAIL midload_rst_err g=%0d got=%b%b exp=11", g, bus.rd_valid, bus.rd_err);
            end
        end
    endtask

    initial begin
        bus.wr_en = 0; bus.wr_data = '0; bus.wr_addr_rst = 0;
        bus.bank_swap = 0; bus.rd_en = 0; bus.rd_group = '0;
        for (int b = 0; b < 2; b++)
            for (int g = 0; g < MAXG; g++) m_mem[b][g] = '0;
        model_reset();
        test_reset();
        test_basic();
        test_rd_err();
        test_overflow();
        test_ping_pong();
        test_simultaneous();
        test_partial_reset();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
